// File: rtl/mf_pkg.sv
// Shared types and helpers for the matched-filter back end.
package mf_pkg;

  localparam int FRAME_LEN_DEF = 2048;

  // Detection record as it appears on the output FIFO: {idx, value}.
  typedef struct packed {
    logic [15:0] idx;
    logic [31:0] value;
  } det_rec_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } pd_state_t;

  // Magnitude key of an IEEE-754 single. Negative values (including -0)
  // collapse to 0, so unsigned compare orders the non-negative range.
  function automatic logic [31:0] f32_key(input logic [31:0] v);
    return v[31] ? 32'd0 : {1'b0, v[30:0]};
  endfunction

endpackage

// File: rtl/mf_peak_window.sv
// Three-tap sliding window (prev key, current sample, incoming sample)
// that flags the current sample as a local maximum above threshold.
module mf_peak_window
  import mf_pkg::*;
#(
  parameter int IDX_W = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             clear,
  input  logic [31:0]      thresh,
  input  logic             shift,
  input  logic             flush,
  input  logic [31:0]      din,
  input  logic [IDX_W-1:0] din_idx,
  output logic             win_valid,
  output logic             peak_valid,
  output det_rec_t         rec
);

  logic [31:0]      thresh_key;
  logic [31:0]      prev_key;
  logic [31:0]      cur_val;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_valid;
  logic [31:0]      cur_key;
  logic [31:0]      next_key;

  // Evaluate the held sample against its neighbours; during flush the
  // right-hand neighbour is the implicit zero past the end of the frame.
  always_comb begin
    cur_key    = f32_key(cur_val);
    next_key   = flush ? 32'd0 : f32_key(din);
    peak_valid = cur_valid && (shift || flush) &&
                 (cur_key > thresh_key) &&
                 (cur_key > prev_key) &&
                 (cur_key >= next_key);
    rec.idx    = 16'(cur_idx);
    rec.value  = cur_val;
    win_valid  = cur_valid;
  end

  // Window shift: prime with prev=0 on frame start, advance on each read.
  always_ff @(posedge ap_clk) begin
    // NOTE: non-blocking assignments, so prev_key captures the pre-edge cur_key.
    if (!ap_rst_n) begin
      thresh_key <= '0;
      prev_key   <= '0;
      cur_val    <= '0;
      cur_idx    <= '0;
      cur_valid  <= 1'b0;
    end else if (clear) begin
      thresh_key <= f32_key(thresh);
      prev_key   <= '0;
      cur_valid  <= 1'b0;
    end else if (shift) begin
      prev_key  <= cur_valid ? cur_key : 32'd0;
      cur_val   <= din;
      cur_idx   <= din_idx;
      cur_valid <= 1'b1;
    end else if (flush) begin
      cur_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/judgment_peak_detect.sv
// Peak detector behind the matched filter: ap_ctrl_hs control, FIFO read
// side for samples, one-deep output register toward the record FIFO.
module judgment_peak_detect
  import mf_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int IDX_W     = 16,
  parameter int MAX_DET   = 64
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  input  logic [31:0]      x_judgment_dout,
  input  logic             x_judgment_empty_n,
  output logic             x_judgment_read,
  input  logic [31:0]      thresh,
  output logic [47:0]      det_din,
  input  logic             det_full_n,
  output logic             det_write,
  output logic [IDX_W-1:0] det_count,
  output logic             det_count_ap_vld
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] MAX_CNT  = IDX_W'(MAX_DET);

  pd_state_t        state, state_nxt;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] count;
  logic             out_full;
  det_rec_t         out_rec;
  logic             ready_q;

  logic     stall;
  logic     rd_last;
  logic     load;
  logic     win_clear;
  logic     win_flush;
  logic     win_valid;
  logic     win_peak;
  det_rec_t win_rec;

  mf_peak_window #(.IDX_W(IDX_W)) u_window (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .clear      (win_clear),
    .thresh     (thresh),
    .shift      (x_judgment_read),
    .flush      (win_flush),
    .din        (x_judgment_dout),
    .din_idx    (rd_idx),
    .win_valid  (win_valid),
    .peak_valid (win_peak),
    .rec        (win_rec)
  );

  // Handshakes, record load decision and next-state logic.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt        = state;
    stall            = out_full && !det_full_n;
    x_judgment_read  = (state == RUN) && x_judgment_empty_n && !stall;
    det_write        = out_full && det_full_n;
    rd_last          = x_judgment_read && (rd_idx == LAST_IDX);
    load             = win_peak && (count < MAX_CNT);
    win_clear        = (state == IDLE) && ap_start;
    win_flush        = (state == FLUSH) && !stall;
    ap_idle          = (state == IDLE);
    ap_done          = (state == DONE);
    det_count_ap_vld = (state == DONE);
    ap_ready         = ready_q;
    det_din          = out_rec;
    det_count        = count;
    unique case (state)
      IDLE:    if (ap_start) state_nxt = RUN;
      RUN:     if (rd_last) state_nxt = FLUSH;
      FLUSH:   if (!win_valid && !out_full) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, read index, record count and the output register.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state    <= IDLE;
      rd_idx   <= '0;
      count    <= '0;
      out_full <= 1'b0;
      out_rec  <= '0;
      ready_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= rd_last;
      if (win_clear) begin
        rd_idx <= '0;
        count  <= '0;
      end else if (x_judgment_read) begin
        rd_idx <= rd_idx + IDX_W'(1);
      end
      // A load can coincide with the drain of the previous record.
      if (load) begin
        out_rec  <= win_rec;
        out_full <= 1'b1;
        count    <= count + IDX_W'(1);
      end else if (det_write) begin
        out_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_judgment_peak_detect.sv
// Frame-level bench for judgment_peak_detect: directed frames plus random
// frames, each compared against a list of expected records computed
// directly from the peak rule.
module tb_judgment_peak_detect;

  localparam int FL = 16;
  localparam logic [31:0] F_HALF  = 32'h3F000000;  // 0.5
  localparam logic [31:0] F_ONE   = 32'h3F800000;  // 1.0
  localparam logic [31:0] F_TWO   = 32'h40000000;  // 2.0
  localparam logic [31:0] F_THREE = 32'h40400000;  // 3.0
  localparam logic [31:0] F_FOUR  = 32'h40800000;  // 4.0
  localparam logic [31:0] F_NFIVE = 32'hC0A00000;  // -5.0

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [1:0]  ap_start;
  logic [1:0]  ap_done, ap_idle, ap_ready, x_read, det_write, cnt_vld;
  logic [31:0] x_dout;
  logic        x_empty_n;
  logic [31:0] thresh;
  logic        det_full_n;
  logic [47:0] det_din [2];
  logic [15:0] det_count [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] samp [FL];
  logic [47:0] exp_q[$];
  logic [47:0] got_q[$];

  always #5 ap_clk = ~ap_clk;

  // Instance 0: full record budget. Instance 1: budget of 3 records.
  judgment_peak_detect #(.FRAME_LEN(FL), .IDX_W(16), .MAX_DET(64)) u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start[0]),
    .ap_done(ap_done[0]), .ap_idle(ap_idle[0]), .ap_ready(ap_ready[0]),
    .x_judgment_dout(x_dout), .x_judgment_empty_n(x_empty_n),
    .x_judgment_read(x_read[0]), .thresh(thresh), .det_din(det_din[0]),
    .det_full_n(det_full_n), .det_write(det_write[0]),
    .det_count(det_count[0]), .det_count_ap_vld(cnt_vld[0]));

  judgment_peak_detect #(.FRAME_LEN(FL), .IDX_W(16), .MAX_DET(3)) u_lim (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start[1]),
    .ap_done(ap_done[1]), .ap_idle(ap_idle[1]), .ap_ready(ap_ready[1]),
    .x_judgment_dout(x_dout), .x_judgment_empty_n(x_empty_n),
    .x_judgment_read(x_read[1]), .thresh(thresh), .det_din(det_din[1]),
    .det_full_n(det_full_n), .det_write(det_write[1]),
    .det_count(det_count[1]), .det_count_ap_vld(cnt_vld[1]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? 32'd0 : (v & 32'h7FFF_FFFF);
  endfunction

  // Expected records straight from the peak rule with zero padding at both ends.
  task automatic build_expected(input logic [31:0] th, input int max_det);
    logic [31:0] k, kp, kn;
    exp_q.delete();
    for (int i = 0; i < FL; i++) begin
      k  = mag(samp[i]);
      kp = (i == 0) ? 32'd0 : mag(samp[i-1]);
      kn = (i == FL - 1) ? 32'd0 : mag(samp[i+1]);
      if (k > mag(th) && k > kp && k >= kn && exp_q.size() < max_det)
        exp_q.push_back({16'(i), samp[i]});
    end
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < FL; i++) samp[i] = base;
  endtask

  // Run one frame on instance sel. full_mode: 0 always ready, 1 random,
  // 2 low for 10 cycles after the first write. reset_after >= 0 aborts the
  // frame with a reset once that many samples are consumed.
  task automatic run_frame(input string tag, input int sel, input int full_mode,
                           input bit rand_empty, input int reset_after,
                           input bit scramble_thresh);
    int rd_n = 0, done_n = 0, ready_n = 0, vld_bad = 0, wr_bad = 0;
    int stall_rd = 0, low_left = 0, over_rd = 0;
    bit first_wr = 0, finished = 0;
    logic [15:0] dc = '0;
    logic [31:0] th;
    th = thresh;
    build_expected(th, sel ? 3 : 64);
    got_q.delete();
    @(negedge ap_clk);
    ap_start[sel] = 1'b1;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      if (reset_after >= 0 && rd_n == reset_after) begin
        ap_rst_n = 1'b0; det_full_n = 1'b1; ap_start[sel] = 1'b0;
        @(negedge ap_clk); #1;
        check({tag, " rst idle"},  ap_idle[sel],   1);
        check({tag, " rst write"}, det_write[sel], 0);
        check({tag, " rst done"},  ap_done[sel],   0);
        check({tag, " rst count"}, det_count[sel], 0);
        ap_rst_n = 1'b1;
        for (int j = 0; j < 30; j++) begin
          @(negedge ap_clk); #1;
          if (det_write[sel] || ap_done[sel] || x_read[sel]) wr_bad++;
        end
        check({tag, " quiet after rst"}, wr_bad, 0);
        return;
      end
      x_empty_n  = rand_empty ? ($urandom_range(0, 3) != 0) : 1'b1;
      x_dout     = (rd_n < FL) ? samp[rd_n] : $urandom;
      case (full_mode)
        1:       det_full_n = ($urandom_range(0, 2) != 0);
        2: begin det_full_n = (low_left == 0); if (low_left > 0) low_left--; end
        default: det_full_n = 1'b1;
      endcase
      #1;
      if (x_read[sel]) begin
        if (rd_n >= FL) over_rd++;
        if (!det_full_n) stall_rd++;
        rd_n++;
      end
      if (det_write[sel]) begin
        if (!det_full_n) wr_bad++;
        got_q.push_back(det_din[sel]);
        if (full_mode == 2 && !first_wr) begin first_wr = 1; low_left = 10; end
      end
      if (ap_ready[sel]) ready_n++;
      if (cnt_vld[sel] != ap_done[sel]) vld_bad++;
      if (ap_done[sel]) begin done_n++; dc = det_count[sel]; finished = 1; end
      if (!ap_idle[sel]) begin
        ap_start[sel] = 1'b0;
        if (scramble_thresh) thresh = $urandom;
      end
      @(negedge ap_clk);
    end
    #1;
    check({tag, " finished"},   finished, 1);
    check({tag, " idle after"}, ap_idle[sel], 1);
    check({tag, " done pulses"}, done_n, 1);
    check({tag, " ready pulses"}, ready_n, 1);
    check({tag, " vld with done"}, vld_bad, 0);
    check({tag, " samples read"}, rd_n, FL);
    check({tag, " over-read"}, over_rd, 0);
    check({tag, " write when full"}, wr_bad, 0);
    check({tag, " det_count"}, dc, exp_q.size());
    check({tag, " record count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s rec%0d", tag, i),
            (i < got_q.size()) ? 64'(got_q[i]) : 64'hDEAD_DEAD_DEAD, exp_q[i]);
    if (full_mode == 2) check({tag, " reads while stalled"}, stall_rd, 1);
    thresh = th;
  endtask

  initial begin
    logic [31:0] pool [7];
    pool = '{F_HALF, F_ONE, F_TWO, F_THREE, 32'hC0000000, 32'h0, 32'h3FC00000};
    ap_rst_n = 1'b0; ap_start = '0; x_dout = '0; x_empty_n = 1'b0;
    det_full_n = 1'b1; thresh = F_ONE;
    repeat (2) @(negedge ap_clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset idle%0d", s),  ap_idle[s], 1);
      check($sformatf("reset done%0d", s),  ap_done[s] | cnt_vld[s] | ap_ready[s], 0);
      check($sformatf("reset rw%0d", s),    x_read[s] | det_write[s], 0);
      check($sformatf("reset din%0d", s),   det_din[s], 0);
      check($sformatf("reset count%0d", s), det_count[s], 0);
    end
    ap_rst_n = 1'b1;

    fill(F_HALF); samp[5] = F_THREE;
    run_frame("single", 0, 0, 0, -1, 0);

    fill(F_HALF); samp[0] = F_TWO; samp[7] = F_TWO; samp[8] = F_TWO; samp[15] = F_FOUR;
    run_frame("edges", 0, 0, 0, -1, 0);

    fill(F_HALF); samp[3] = F_NFIVE; samp[9] = F_ONE;
    run_frame("neg", 0, 0, 0, -1, 0);

    fill(F_HALF); samp[2] = F_TWO; samp[4] = F_TWO; samp[6] = F_TWO; samp[8] = F_TWO;
    run_frame("bp", 0, 2, 0, -1, 0);

    fill(F_HALF);
    for (int i = 1; i < 10; i += 2) samp[i] = F_THREE;
    run_frame("maxdet", 1, 0, 0, -1, 0);

    fill(F_HALF); samp[5] = F_THREE;
    run_frame("midrst", 0, 0, 0, 8, 0);
    fill(F_HALF); samp[0] = F_TWO; samp[7] = F_TWO; samp[8] = F_TWO; samp[15] = F_FOUR;
    run_frame("postrst", 0, 0, 0, -1, 0);

    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < FL; i++) samp[i] = pool[$urandom_range(0, 6)];
      thresh = pool[$urandom_range(0, 6)];
      run_frame($sformatf("rand%0d", f), int'($urandom_range(0, 1)),
                1, 1'($urandom_range(0, 1)), -1, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
